multi_phase_sig_control: RTL and testbench
==========================================

// Module: multi_phase_sig_control
// PURPOSE
//  Sensor-actuated traffic signal controller generalised to NUM_PH approaches (phases) with
//  counter-based yellow/all-red/min-green/max-green timing. Phase 0 is the main-road rest phase.
//  Sits between per-approach vehicle sensors and the lamp drivers; one 2-bit signal field per phase.
//  Lamp code per field: RED=2'd0, YELLOW=2'd1, GREEN=2'd2 (2'd3 never driven).
// PARAMETERS
//  NUM_PH  2   number of phases, 2..8
//  TW      8   timer width in bits; must satisfy MAX_G <= 2**TW-1
//  Y_CYC   3   yellow duration, clock cycles, >=1
//  R_CYC   2   all-red clearance duration, clock cycles, >=1
//  MIN_G   4   minimum green, clock cycles, >=1
//  MAX_G   20  maximum green when conflicting demand is present, >=MIN_G
// PORTS
//  clk     in   1           system clock, all logic on posedge
//  clr     in   1           synchronous active-high reset
//  demand  in   NUM_PH      per-phase vehicle sensor, level, already synchronous to clk
//  sig     out  2*NUM_PH    lamp code; field p = sig[2p+1:2p]
//  act_ph  out  PW          phase currently owning right-of-way; PW = clog2(NUM_PH), min 1
//  st      out  2           controller state: 0=GREEN, 1=YELLOW, 2=ALLRED
// BEHAVIOUR
//  - All outputs registered. Lamp changes on the same edge as the state change; no comb. path from demand.
//  - Reset (clr=1 at posedge, any state, any timer value): st=GREEN, act_ph=0, timer=0, nxt_ph=0,
//    sig field 0 = GREEN, all other fields = RED. Reset mid-yellow/all-red aborts the clearance.
//  - Effective demand eff[q] = demand[q] for q!=0; eff[0] = 1 whenever act_ph!=0 (rest phase always
//    requested); eff[0] = demand[0] while act_ph==0.
//  - other_req = OR of eff[q] for q!=act_ph.
//  - Timer clears to 0 on every state entry, increments by 1 each cycle in the state, saturates at 2**TW-1.
//  - GREEN(p): field p=GREEN, others RED. Exit to YELLOW when
//    other_req && timer>=MIN_G-1 && (!eff[p] || timer>=MAX_G-1).
//    No other_req -> green held indefinitely (no max-out).
//    On exit latch nxt_ph = first q in round-robin order p+1, p+2, ... (mod NUM_PH), q!=p, with eff[q]=1.
//  - YELLOW(p): field p=YELLOW, others RED; exactly Y_CYC cycles, then ALLRED.
//  - ALLRED: all fields RED; exactly R_CYC cycles, then GREEN with act_ph<=nxt_ph.
//  - Demand changes during YELLOW/ALLRED do not alter nxt_ph. Demand drop on nxt_ph still grants
//    it MIN_G green.
//  - Green duration = timer cycles at exit + 1. Min cycle per served phase = MIN_G + Y_CYC + R_CYC.
//  - Invariant: at most one field non-RED in any cycle; never GREEN->RED without YELLOW.
// CONFIGURATION
//  PED_WALK_EN defined: adds ped_req in NUM_PH (pulse/level) and walk out NUM_PH, plus param WALK_CYC
//    (default 6). ped_req[q] sets sticky pend[q]; pend[q] ORs into eff[q]. On GREEN entry of phase p
//    with pend[p]=1: walk[p]=1 for the first WALK_CYC green cycles; pend[p] clears on the entry edge.
//    The effective minimum green for that phase is max(MIN_G, WALK_CYC). walk resets to 0, pend to 0.
//    A ped_req arriving during its own walk re-sets pend for the next service.
//  PED_WALK_EN undefined: no ped_req/walk ports, no pend state; behaviour exactly as above.
// TESTING
//  1 Reset: clr high 2 cycles -> sig=4'b0010 (ph0 GREEN, ph1 RED), act_ph=0, st=0.
//  2 Actuation (defaults): demand=2'b10 from reset release -> ph0 GREEN 4 cycles, YELLOW 3,
//    all-RED 2, ph1 GREEN; drop demand[1] after 10 cycles -> ph1 YELLOW 3, all-RED 2, back to ph0.
//  3 Max-out: demand=2'b11 held -> ph0 green exactly 20 cycles, then ph1 green exactly 20 cycles,
//    alternating; at most one non-RED field each cycle.
//  4 Round-robin NUM_PH=4: at ph1 exit, demand=4'b1010 -> next served ph3; ph2 skipped.
//    Then ph3 exits to ph0.
//  5 Reset mid-operation: assert clr on 2nd YELLOW cycle of ph1 -> next edge sig=ph0 GREEN, timer=0;
//    no all-red.
//  6 PED_WALK_EN, WALK_CYC=6: 1-cycle ped_req[1] pulse, no vehicle demand -> ph1 served;
//    walk[1]=1 for 6 cycles; ph1 green 6 cycles; pend[1]=0.

Source files
------------

// File: rtl/multi_phase_sig_control.sv
// Sensor-actuated multi-phase traffic signal controller with yellow/all-red/min/max green timing.
// Optional pedestrian walk service is compiled in when PED_WALK_EN is defined.
module multi_phase_sig_control #(
    parameter int unsigned NUM_PH   = 2,
    parameter int unsigned TW       = 8,
    parameter int unsigned Y_CYC    = 3,
    parameter int unsigned R_CYC    = 2,
    parameter int unsigned MIN_G    = 4,
    parameter int unsigned MAX_G    = 20,
`ifdef PED_WALK_EN
    parameter int unsigned WALK_CYC = 6,
`endif
    localparam int unsigned PW      = (NUM_PH > 1) ? $clog2(NUM_PH) : 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NUM_PH-1:0]   demand,
`ifdef PED_WALK_EN
    input  logic [NUM_PH-1:0]   ped_req,
    output logic [NUM_PH-1:0]   walk,
`endif
    output logic [2*NUM_PH-1:0] sig,
    output logic [PW-1:0]       act_ph,
    output logic [1:0]          st
);

    localparam logic [1:0] S_GREEN  = 2'd0;
    localparam logic [1:0] S_YELLOW = 2'd1;
    localparam logic [1:0] S_ALLRED = 2'd2;

    localparam logic [1:0] L_RED = 2'd0;
    localparam logic [1:0] L_YEL = 2'd1;
    localparam logic [1:0] L_GRN = 2'd2;

    localparam logic [TW-1:0] T_SAT  = '1;
    localparam logic [TW-1:0] T_MING = TW'(MIN_G - 1);
    localparam logic [TW-1:0] T_MAXG = TW'(MAX_G - 1);
    localparam logic [TW-1:0] T_Y    = TW'(Y_CYC - 1);
    localparam logic [TW-1:0] T_R    = TW'(R_CYC - 1);
    localparam logic [2*NUM_PH-1:0] SIG_RST = (2*NUM_PH)'(L_GRN);
`ifdef PED_WALK_EN
    localparam logic [TW-1:0] T_WALK = TW'(WALK_CYC - 1);
    localparam logic [TW-1:0] T_WMIN = TW'(((WALK_CYC > MIN_G) ? WALK_CYC : MIN_G) - 1);
`endif

    logic [1:0]          st_q, st_d;
    logic [PW-1:0]       act_ph_q, act_ph_d;
    logic [PW-1:0]       nxt_ph_q, nxt_ph_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [2*NUM_PH-1:0] sig_q, sig_d;
`ifdef PED_WALK_EN
    logic [NUM_PH-1:0]   pend_q, pend_d;
    logic [NUM_PH-1:0]   walk_q, walk_d;
    logic                walk_g_q, walk_g_d;
`endif

    logic [NUM_PH-1:0] eff, rival;
    logic              other_req, g_exit, rr_found;
    logic [PW-1:0]     rr_ph, cand;
    logic [TW-1:0]     min_thr;

    // The rest phase is implicitly requested whenever another phase holds right-of-way.
    always_comb begin
        eff = demand;
`ifdef PED_WALK_EN
        eff = demand | pend_q;
`endif
        if (act_ph_q != '0) eff[0] = 1'b1;
        rival = eff;
        rival[act_ph_q] = 1'b0;
        other_req = |rival;

        rr_ph    = act_ph_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i < NUM_PH; i++) begin
            cand = PW'((32'(act_ph_q) + i) % NUM_PH);
            if (!rr_found && eff[cand]) begin
                rr_ph    = cand;
                rr_found = 1'b1;
            end
        end

        min_thr = T_MING;
`ifdef PED_WALK_EN
        if (walk_g_q) min_thr = T_WMIN;
`endif
        g_exit = other_req && (timer_q >= min_thr) && (!eff[act_ph_q] || (timer_q >= T_MAXG));
    end

    always_comb begin
        st_d     = st_q;
        act_ph_d = act_ph_q;
        nxt_ph_d = nxt_ph_q;
        timer_d  = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
`ifdef PED_WALK_EN
        pend_d   = pend_q | ped_req;
        walk_d   = walk_q;
        walk_g_d = walk_g_q;
        if (st_q == S_GREEN && timer_q == T_WALK) walk_d = '0;
`endif
        case (st_q)
            S_GREEN: begin
                if (g_exit) begin
                    st_d     = S_YELLOW;
                    timer_d  = '0;
                    nxt_ph_d = rr_ph;
                end
            end
            S_YELLOW: begin
                if (timer_q == T_Y) begin
                    st_d    = S_ALLRED;
                    timer_d = '0;
                end
            end
            S_ALLRED: begin
                if (timer_q == T_R) begin
                    st_d     = S_GREEN;
                    timer_d  = '0;
                    act_ph_d = nxt_ph_q;
`ifdef PED_WALK_EN
                    // Entry consumes the pending request; a same-edge request re-arms it.
                    walk_d           = '0;
                    walk_d[nxt_ph_q] = pend_q[nxt_ph_q];
                    walk_g_d         = pend_q[nxt_ph_q];
                    pend_d[nxt_ph_q] = ped_req[nxt_ph_q];
`endif
                end
            end
            default: begin
                st_d    = S_GREEN;
                timer_d = '0;
            end
        endcase

        sig_d = '0;
        for (int unsigned p = 0; p < NUM_PH; p++) begin
            sig_d[2*p +: 2] = L_RED;
            if (act_ph_d == PW'(p)) begin
                if (st_d == S_GREEN)       sig_d[2*p +: 2] = L_GRN;
                else if (st_d == S_YELLOW) sig_d[2*p +: 2] = L_YEL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st_q     <= S_GREEN;
            act_ph_q <= '0;
            nxt_ph_q <= '0;
            timer_q  <= '0;
            sig_q    <= SIG_RST;
`ifdef PED_WALK_EN
            pend_q   <= '0;
            walk_q   <= '0;
            walk_g_q <= 1'b0;
`endif
        end else begin
            st_q     <= st_d;
            act_ph_q <= act_ph_d;
            nxt_ph_q <= nxt_ph_d;
            timer_q  <= timer_d;
            sig_q    <= sig_d;
`ifdef PED_WALK_EN
            pend_q   <= pend_d;
            walk_q   <= walk_d;
            walk_g_q <= walk_g_d;
`endif
        end
    end

    assign sig    = sig_q;
    assign act_ph = act_ph_q;
    assign st     = st_q;
`ifdef PED_WALK_EN
    assign walk   = walk_q;
`endif

endmodule

// File: tb/tb_multi_phase_sig_control.sv
// Bench for multi_phase_sig_control: cycle table, hand-written corner sequences, and
// randomized demand against a phase/stage/elapsed-time reference model (2- and 4-phase builds).
module tb_multi_phase_sig_control;

    localparam int YC = 3, RC = 2, MING = 4, MAXG = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr2 = 1'b1, clr4 = 1'b1;
    logic [1:0] dem2 = '0;
    logic [3:0] dem4 = '0;
    logic [3:0] sig2;
    logic [7:0] sig4;
    logic       act2;
    logic [1:0] act4;
    logic [1:0] st2, st4;
`ifdef PED_WALK_EN
    logic [1:0] ped2 = '0, walk2;
    logic [3:0] ped4 = '0, walk4;
`endif

    multi_phase_sig_control #(.NUM_PH(2)) u_dut2 (
        .clk(clk), .clr(clr2), .demand(dem2),
`ifdef PED_WALK_EN
        .ped_req(ped2), .walk(walk2),
`endif
        .sig(sig2), .act_ph(act2), .st(st2)
    );

    multi_phase_sig_control #(.NUM_PH(4)) u_dut4 (
        .clk(clk), .clr(clr4), .demand(dem4),
`ifdef PED_WALK_EN
        .ped_req(ped4), .walk(walk4),
`endif
        .sig(sig4), .act_ph(act4), .st(st4)
    );

    int n_tests = 0, n_fail = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int g_st(input int k);
        return (k == 0) ? int'(st2) : int'(st4);
    endfunction

    function automatic int g_act(input int k);
        return (k == 0) ? int'(act2) : int'(act4);
    endfunction

    // Counts consecutive green cycles starting with the current one (bounded).
    task automatic count_green(input int k, output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (g_st(k) != 0) break;
            cnt++;
            cyc();
        end
    endtask

    task automatic wait_green(input int k, output int ph);
        ph = -1;
        for (int i = 0; i < 50; i++) begin
            if (g_st(k) == 0) begin
                ph = g_act(k);
                break;
            end
            cyc();
        end
    endtask

    // Reference model: stage 0/1/2 = green/yellow/all-red, el = cycles already spent in stage.
    int m_stage[2], m_ph[2], m_nxt[2], m_el[2];

    task automatic model_step(input int k, input int n, input logic c, input logic [3:0] dem);
        bit want[4];
        bit others;
        if (c) begin
            m_stage[k] = 0; m_ph[k] = 0; m_nxt[k] = 0; m_el[k] = 0;
        end else begin
            for (int q = 0; q < n; q++)
                want[q] = (q == 0) ? (m_ph[k] != 0 || dem[0]) : dem[q];
            others = 0;
            for (int q = 0; q < n; q++)
                if (q != m_ph[k] && want[q]) others = 1;
            case (m_stage[k])
                0: if (others && m_el[k] + 1 >= MING && (!want[m_ph[k]] || m_el[k] + 1 >= MAXG)) begin
                       m_stage[k] = 1;
                       m_el[k] = 0;
                       for (int i = 1; i < n; i++) begin
                           if (want[(m_ph[k] + i) % n]) begin
                               m_nxt[k] = (m_ph[k] + i) % n;
                               break;
                           end
                       end
                   end else m_el[k]++;
                1: if (m_el[k] + 1 == YC) begin m_stage[k] = 2; m_el[k] = 0; end else m_el[k]++;
                default: if (m_el[k] + 1 == RC) begin
                             m_stage[k] = 0; m_ph[k] = m_nxt[k]; m_el[k] = 0;
                         end else m_el[k]++;
            endcase
        end
    endtask

    function automatic int exp_sig(input int k);
        if (m_stage[k] == 0) return 2 << (2 * m_ph[k]);
        if (m_stage[k] == 1) return 1 << (2 * m_ph[k]);
        return 0;
    endfunction

    typedef struct {
        logic       clr;
        logic [1:0] dem;
        int         n;
        logic [1:0] st;
        logic       act;
        logic [3:0] sig;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int c, ph;
        logic [1:0] rd2;
        logic [3:0] rd4;
        logic       rc;

        // Reset, actuation to ph1, ph1 release, return, reset mid-yellow of ph1.
        vecs.push_back('{1'b1, 2'b00,  2, 2'd0, 1'b0, 4'b0010});
        vecs.push_back('{1'b0, 2'b10,  3, 2'd0, 1'b0, 4'b0010});
        vecs.push_back('{1'b0, 2'b10,  3, 2'd1, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 2'b10,  2, 2'd2, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 2'b10, 10, 2'd0, 1'b1, 4'b1000});
        vecs.push_back('{1'b0, 2'b00,  3, 2'd1, 1'b1, 4'b0100});
        vecs.push_back('{1'b0, 2'b00,  2, 2'd2, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 2'b00,  4, 2'd0, 1'b0, 4'b0010});
        vecs.push_back('{1'b0, 2'b10,  3, 2'd1, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 2'b10,  2, 2'd2, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 2'b00,  4, 2'd0, 1'b1, 4'b1000});
        vecs.push_back('{1'b0, 2'b00,  2, 2'd1, 1'b1, 4'b0100});
        vecs.push_back('{1'b1, 2'b00,  1, 2'd0, 1'b0, 4'b0010});
        vecs.push_back('{1'b0, 2'b10,  3, 2'd0, 1'b0, 4'b0010});
        vecs.push_back('{1'b0, 2'b10,  1, 2'd1, 1'b0, 4'b0001});

        for (int i = 0; i < vecs.size(); i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                clr2 = vecs[i].clr;
                dem2 = vecs[i].dem;
                cyc();
                chk($sformatf("vec%0d.%0d st", i, j),  int'(st2),  int'(vecs[i].st));
                chk($sformatf("vec%0d.%0d act", i, j), int'(act2), int'(vecs[i].act));
                chk($sformatf("vec%0d.%0d sig", i, j), int'(sig2), int'(vecs[i].sig));
            end
        end

        // Max-out alternation with both approaches requesting.
        clr2 = 1'b1; dem2 = 2'b11;
        cyc();
        clr2 = 1'b0;
        count_green(0, c);  chk("maxout ph0 first", c, 20);
        wait_green(0, ph);  chk("maxout to ph1", ph, 1);
        count_green(0, c);  chk("maxout ph1", c, 20);
        wait_green(0, ph);  chk("maxout back ph0", ph, 0);
        count_green(0, c);  chk("maxout ph0 second", c, 20);

        // Round-robin skip on the 4-phase build.
        clr4 = 1'b1; dem4 = 4'b0010;
        cyc();
        clr4 = 1'b0;
        count_green(1, c);  chk("rr ph0 min green", c, 4);
        wait_green(1, ph);  chk("rr serve ph1", ph, 1);
        dem4 = 4'b1010;
        count_green(1, c);  chk("rr ph1 maxout", c, 20);
        wait_green(1, ph);  chk("rr skip to ph3", ph, 3);
        count_green(1, c);  chk("rr ph3 maxout", c, 20);
        wait_green(1, ph);  chk("rr wrap to ph0", ph, 0);

`ifdef PED_WALK_EN
        begin
            int cg, cw;
            clr2 = 1'b1; dem2 = '0; ped2 = '0;
            cyc();
            clr2 = 1'b0;
            repeat (6) cyc();
            ped2 = 2'b10;
            cyc();
            ped2 = 2'b00;
            count_green(0, c);
            wait_green(0, ph);  chk("ped serve ph1", ph, 1);
            cg = 0; cw = 0;
            for (int i = 0; i < 50; i++) begin
                if (st2 != 2'd0) break;
                cg++;
                cw += int'(walk2[1]);
                cyc();
            end
            chk("ped ph1 green", cg, 6);
            chk("ped walk cycles", cw, 6);
            wait_green(0, ph);  chk("ped back ph0", ph, 0);
            repeat (15) cyc();
            chk("ped pend cleared st", int'(st2), 0);
            chk("ped pend cleared act", int'(act2), 0);
        end
`endif

        // Randomized demand against the reference model on both builds.
        clr2 = 1'b1; clr4 = 1'b1; dem2 = '0; dem4 = '0;
        model_step(0, 2, 1'b1, 4'b0);
        model_step(1, 4, 1'b1, 4'b0);
        cyc();
        rd2 = '0; rd4 = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) rd2 = 2'($urandom);
            if ($urandom_range(0, 7) == 0) rd4 = 4'($urandom);
            rc = ($urandom_range(0, 499) == 0);
            clr2 = rc; clr4 = rc; dem2 = rd2; dem4 = rd4;
            model_step(0, 2, rc, {2'b00, rd2});
            model_step(1, 4, rc, rd4);
            cyc();
            chk($sformatf("rnd%0d n2 st", i),  int'(st2),  m_stage[0]);
            chk($sformatf("rnd%0d n2 act", i), int'(act2), m_ph[0]);
            chk($sformatf("rnd%0d n2 sig", i), int'(sig2), exp_sig(0));
            chk($sformatf("rnd%0d n4 st", i),  int'(st4),  m_stage[1]);
            chk($sformatf("rnd%0d n4 act", i), int'(act4), m_ph[1]);
            chk($sformatf("rnd%0d n4 sig", i), int'(sig4), exp_sig(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
